// File: rtl/arith_pkg.sv
// Shared arithmetic-unit constants and the divider state encoding.
package arith_pkg;

    // Dividend/quotient width (also the iteration count) and divisor/remainder width.
    localparam int DW_N  = 16;
    localparam int DW_D  = 8;
    localparam int CNT_W = $clog2(DW_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try the subtract.
module div_step
    import arith_pkg::*;
(
    input  logic [DW_D:0]   p,
    input  logic            q_msb,
    input  logic [DW_D-1:0] divisor,
    output logic [DW_D:0]   p_next,
    output logic            q_bit
);

    logic [DW_D:0]   shifted;
    logic [DW_D+1:0] diff;

    // Subtract one bit wider than P so the top bit is a clean borrow flag.
    always_comb begin
        shifted = {p[DW_D-1:0], q_msb};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~diff[DW_D+1];
        p_next  = diff[DW_D+1] ? shifted : diff[DW_D:0];
    end

endmodule

// File: rtl/vedic_divider_16by8.sv
// Sequential 16/8 restoring divider with valid/ready on both sides.
module vedic_divider_16by8
    import arith_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_by_zero,
    output logic            q_ovf
);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [DW_N-1:0]  q_reg, q_next;
    logic [DW_D:0]    p_reg, p_next;
    logic [DW_D-1:0]  dsr_reg, dsr_next;
    logic [DW_N-1:0]  quotient_reg, quotient_next;
    logic [DW_D-1:0]  remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;
    logic             ovf_reg, ovf_next;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;

    logic [DW_D:0]    step_p;
    logic             step_q_bit;

    div_step u_step (
        .p       (p_reg),
        .q_msb   (q_reg[DW_N-1]),
        .divisor (dsr_reg),
        .p_next  (step_p),
        .q_bit   (step_q_bit)
    );

    // Next-state and datapath decode; DONE spends its first cycle loading the result registers.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        q_next         = q_reg;
        p_next         = p_reg;
        dsr_next       = dsr_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        ovf_next       = ovf_reg;
        in_ready_next  = in_ready_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    in_ready_next = 1'b0;
                    dsr_next      = divisor;
                    cnt_next      = '0;
                    if (divisor != '0) begin
                        q_next     = dividend;
                        p_next     = '0;
                        state_next = BUSY;
                    end else begin
                        // Divide-by-zero skips iteration; the result is preloaded into Q/P.
                        q_next     = '1;
                        p_next     = {1'b0, dividend[DW_D-1:0]};
                        state_next = DONE;
                    end
                end
            end
            BUSY: begin
                q_next   = {q_reg[DW_N-2:0], step_q_bit};
                p_next   = step_p;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(DW_N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!out_valid_reg) begin
                    quotient_next  = q_reg;
                    remainder_next = p_reg[DW_D-1:0];
                    dbz_next       = (dsr_reg == '0);
                    ovf_next       = (dsr_reg != '0) && (|q_reg[DW_N-1:DW_D]);
                    out_valid_next = 1'b1;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            q_reg         <= '0;
            p_reg         <= '0;
            dsr_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            q_reg         <= q_next;
            p_reg         <= p_next;
            dsr_reg       <= dsr_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
            ovf_reg       <= ovf_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign q_ovf       = ovf_reg;

endmodule

// File: tb/tb_vedic_divider_16by8.sv
// Directed and product-soak checks for the 16/8 restoring divider.
module tb_vedic_divider_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        q_ovf;

    int checks_total  = 0;
    int checks_passed = 0;

    vedic_divider_16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .q_ovf       (q_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present operands for exactly one accepting edge.
    task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        in_valid = 1'b0;
    endtask

    // Count clocks from the accepting edge until out_valid, bounded.
    task automatic wait_result(input int exp_lat, input string tag);
        int lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 40);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_result(input string tag, input logic [15:0] eq, input logic [7:0] er,
                                input logic edbz, input logic eovf);
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(edbz));
        check({tag, "_q_ovf"}, 32'(q_ovf), 32'(eovf));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                         input logic [15:0] eq, input logic [7:0] er,
                         input logic edbz, input logic eovf, input bit verbose);
        start_op(dd, dv);
        wait_result((dv == 8'd0) ? 1 : 17, tag);
        check_result(tag, eq, er, edbz, eovf);
        if (verbose)
            $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b",
                     tag, dd, dv, quotient, remainder, div_by_zero, q_ovf);
        handshake(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_result("rst", 16'd0, 8'd0, 1'b0, 1'b0);

        // Directed vectors
        do_op("t1", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 1'b0, 1'b1);
        do_op("t2", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0, 1'b1);
        do_op("t3", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 1'b1, 1'b1);
        do_op("t4", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1'b0, 1'b1);
        // Result persists in IDLE after the handshake
        check_result("t4_idle_hold", 16'hFFFF, 8'h34, 1'b1, 1'b0);
        do_op("small", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 1'b0, 1'b1);
        do_op("zero", 16'd0, 8'd3, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1);

        // Backpressure: DONE held with new operands pending
        start_op(16'd5000, 8'd50);
        wait_result(17, "t5");
        in_valid = 1'b1;
        dividend = 16'd300;
        divisor  = 8'd17;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_out_valid", 32'(out_valid), 32'd1);
            check("t5_hold_in_ready", 32'(in_ready), 32'd0);
            check_result("t5_hold", 16'd100, 8'd0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        $display("op t5: 5000 / 50 held 5 cycles -> q=%0d r=%0d", quotient, remainder);
        handshake("t5");
        do_op("t5_next", 16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 1'b0, 1'b1);

        // Reset mid-iteration at cnt=8
        start_op(16'd200, 8'd3);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        $display("op t6: reset during BUSY, in_ready=%0b out_valid=%0b", in_ready, out_valid);
        do_op("t6_fresh", 16'd100, 8'd9, 16'd11, 8'd1, 1'b0, 1'b0, 1'b1);

        // Soak: products of 8x8 factors divide back exactly
        for (int n = 0; n < 2000; n++) begin
            logic [7:0]  a;
            logic [7:0]  b;
            logic [15:0] prod;
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(1, 255));
            prod = 16'(a) * 16'(b);
            do_op("soak", prod, b, 16'(a), 8'd0, 1'b0, 1'b0, 1'b0);
        end
        $display("op soak: 2000 factor products divided");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
